// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: CDB tag width, depvals bundle and the
// reservation-station entry layout used by the hash RS and its FU.
package ooo_pkg;

  localparam int unsigned TAG_W = 4;

  typedef logic [1:0][7:0] depvals_t;

  typedef struct packed {
    logic                  valid;
    logic [7:0]            operand;
    logic [1:0]            rdy;
    logic [1:0][TAG_W-1:0] tag;
    depvals_t              val;
    logic [7:0]            wbs;
    logic [7:0]            flags;
    logic [3:0]            robid;
  } rs_entry_t;

endpackage

// File: rtl/hash_rs_if.sv
// Dispatch, CDB snoop and FU issue signals of the hash reservation station.
// The RS itself uses the slave modport; the surrounding pipeline drives master.
interface hash_rs_if #(
  parameter int unsigned DEPTH = 4
);
  import ooo_pkg::*;

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  disp_valid;
  logic                  disp_ready;
  logic [7:0]            disp_operand;
  logic [1:0]            disp_src_rdy;
  logic [1:0][TAG_W-1:0] disp_src_tag;
  depvals_t              disp_src_val;
  logic [7:0]            disp_wbs;
  logic [7:0]            disp_flags;
  logic [3:0]            disp_robid;

  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_id;
  logic [7:0]            cdb_val;

  logic                  fu_hold;
  logic                  fu_issue;
  logic [7:0]            fu_operand;
  depvals_t              fu_depvals;
  logic [7:0]            fu_wbs;
  logic [7:0]            fu_flags;
  logic [3:0]            fu_robid;

  logic [OCC_W-1:0]      occupancy;

  modport master (
    output flush, disp_valid, disp_operand, disp_src_rdy, disp_src_tag, disp_src_val,
    output disp_wbs, disp_flags, disp_robid, cdb_valid, cdb_id, cdb_val, fu_hold,
    input  disp_ready, fu_issue, fu_operand, fu_depvals, fu_wbs, fu_flags, fu_robid,
    input  occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_operand, disp_src_rdy, disp_src_tag, disp_src_val,
    input  disp_wbs, disp_flags, disp_robid, cdb_valid, cdb_id, cdb_val, fu_hold,
    output disp_ready, fu_issue, fu_operand, fu_depvals, fu_wbs, fu_flags, fu_robid,
    output occupancy
  );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder: returns the index of the lowest set
// request bit and whether any bit is set.
module rs_prio_enc #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_rs.sv
// Reservation station feeding the hash FU: buffers dispatched ops, snoops the
// CDB for missing sources and issues the lowest-index ready op per cycle.
module hash_rs
  import ooo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  hash_rs_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = IDX_W + 1;

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        new_ent;
  rs_entry_t        sel_ent;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] elig_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             free_any;
  logic             sel_any;
  logic             accept;
  logic             issue;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    free_vec = '0;
    elig_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = ~ent_q[i].valid;
      elig_vec[i] = ent_q[i].valid & ent_q[i].rdy[0] & ent_q[i].rdy[1];
    end
  end

  rs_prio_enc #(.N(DEPTH)) u_free_enc (
    .req (free_vec),
    .idx (free_idx),
    .any (free_any)
  );

  rs_prio_enc #(.N(DEPTH)) u_sel_enc (
    .req (elig_vec),
    .idx (sel_idx),
    .any (sel_any)
  );

  assign accept  = bus.disp_valid & free_any;
  assign issue   = ~bus.fu_hold & sel_any;
  assign sel_ent = ent_q[sel_idx];

  // Incoming op, with sources captured from a same-cycle CDB broadcast.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.operand = bus.disp_operand;
    new_ent.tag     = bus.disp_src_tag;
    new_ent.wbs     = bus.disp_wbs;
    new_ent.flags   = bus.disp_flags;
    new_ent.robid   = bus.disp_robid;
    for (int s = 0; s < 2; s++) begin
      if (!bus.disp_src_rdy[s] && bus.cdb_valid && (bus.disp_src_tag[s] == bus.cdb_id)) begin
        new_ent.rdy[s] = 1'b1;
        new_ent.val[s] = bus.cdb_val;
      end else begin
        new_ent.rdy[s] = bus.disp_src_rdy[s];
        new_ent.val[s] = bus.disp_src_val[s];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      for (int s = 0; s < 2; s++) begin
        if (ent_q[i].valid && !ent_q[i].rdy[s] && bus.cdb_valid &&
            (ent_q[i].tag[s] == bus.cdb_id)) begin
          ent_d[i].rdy[s] = 1'b1;
          ent_d[i].val[s] = bus.cdb_val;
        end
      end
      if (issue && (sel_idx == IDX_W'(i))) begin
        ent_d[i].valid = 1'b0;
      end
      if (accept && (free_idx == IDX_W'(i))) begin
        ent_d[i] = new_ent;
      end
      if (bus.flush) begin
        ent_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(issue);
    if (bus.flush) begin
      occ_d = '0;
    end
  end

  // Only valid bits need reset; payload is qualified by valid everywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      occ_q <= occ_d;
    end
  end

  always_comb begin
    bus.disp_ready = free_any;
    bus.fu_issue   = issue;
    bus.fu_operand = issue ? sel_ent.operand : '0;
    bus.fu_depvals = issue ? sel_ent.val : '0;
    bus.fu_wbs     = issue ? sel_ent.wbs : '0;
    bus.fu_flags   = issue ? sel_ent.flags : '0;
    bus.fu_robid   = issue ? sel_ent.robid : '0;
    bus.occupancy  = occ_q;
  end

endmodule

// File: tb/tb_hash_rs.sv
// Bench for hash_rs: table of single-op dispatch/issue cases, hand-written
// multi-cycle sequences, then randomized traffic against an array model.
module tb_hash_rs;
  import ooo_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hash_rs_if #(.DEPTH(DEPTH)) bus ();

  hash_rs #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.disp_valid   = 1'b0;
    bus.disp_operand = '0;
    bus.disp_src_rdy = '0;
    bus.disp_src_tag = '0;
    bus.disp_src_val = '0;
    bus.disp_wbs     = '0;
    bus.disp_flags   = '0;
    bus.disp_robid   = '0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_id       = '0;
    bus.cdb_val      = '0;
    bus.fu_hold      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic disp(input logic [7:0] op, input logic [1:0] rdy, input logic [7:0] tags,
                      input logic [15:0] vals, input logic [7:0] wbs, input logic [3:0] rob);
    bus.disp_valid   = 1'b1;
    bus.disp_operand = op;
    bus.disp_src_rdy = rdy;
    bus.disp_src_tag = tags;
    bus.disp_src_val = vals;
    bus.disp_wbs     = wbs;
    bus.disp_flags   = op ^ 8'h5A;
    bus.disp_robid   = rob;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [1:0]  rdy;
    logic [7:0]  tags;
    logic [15:0] vals;
    logic [7:0]  wbs;
    logic [3:0]  rob;
    logic        cdb_v;
    logic [3:0]  cdb_id;
    logic [7:0]  cdb_val;
    logic [15:0] exp_dep;
  } vec_t;

  vec_t vt[4];

  // Behavioural model state
  logic       m_v   [DEPTH];
  logic [1:0] m_rdy [DEPTH];
  logic [7:0] m_tag [DEPTH];
  logic [15:0] m_val [DEPTH];
  logic [7:0] m_op  [DEPTH];
  logic [7:0] m_wbs [DEPTH];
  logic [7:0] m_flg [DEPTH];
  logic [3:0] m_rob [DEPTH];

  task automatic model_cycle(output logic [63:0] exp_out);
    int sel = -1;
    int fr = -1;
    int cnt = 0;
    logic e_issue, e_ready;
    logic [15:0] dv;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_v[i] && m_rdy[i] == 2'b11) sel = i;
      if (!m_v[i]) fr = i;
      if (m_v[i]) cnt++;
    end
    e_issue = !bus.fu_hold && sel >= 0;
    e_ready = cnt < DEPTH;
    exp_out = '0;
    if (e_issue)
      exp_out = {15'd0, e_ready, 1'b1, m_op[sel], m_val[sel], m_wbs[sel], m_flg[sel],
                 m_rob[sel], 3'(cnt)};
    else
      exp_out = {15'd0, e_ready, 1'b0, 44'd0, 3'(cnt)};
    for (int i = 0; i < DEPTH; i++)
      for (int s = 0; s < 2; s++)
        if (m_v[i] && !m_rdy[i][s] && bus.cdb_valid && m_tag[i][4*s+:4] == bus.cdb_id) begin
          m_rdy[i][s] = 1'b1;
          m_val[i][8*s+:8] = bus.cdb_val;
        end
    if (e_issue) m_v[sel] = 1'b0;
    if (bus.disp_valid && e_ready) begin
      dv = bus.disp_src_val;
      m_rdy[fr] = bus.disp_src_rdy;
      for (int s = 0; s < 2; s++)
        if (!bus.disp_src_rdy[s] && bus.cdb_valid && bus.disp_src_tag[s] == bus.cdb_id) begin
          m_rdy[fr][s] = 1'b1;
          dv[8*s+:8] = bus.cdb_val;
        end
      m_v[fr] = 1'b1;
      m_val[fr] = dv;
      m_tag[fr] = bus.disp_src_tag;
      m_op[fr] = bus.disp_operand;
      m_wbs[fr] = bus.disp_wbs;
      m_flg[fr] = bus.disp_flags;
      m_rob[fr] = bus.disp_robid;
    end
    if (bus.flush)
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
  endtask

  function automatic logic [63:0] dut_out();
    return {15'd0, bus.disp_ready, bus.fu_issue, bus.fu_operand, bus.fu_depvals, bus.fu_wbs,
            bus.fu_flags, bus.fu_robid, bus.occupancy};
  endfunction

  initial begin
    logic [63:0] e;
    vt[0] = '{8'h12, 2'b11, 8'h00, 16'h0507, 8'h03, 4'd2, 1'b0, 4'd0, 8'h00, 16'h0507};
    vt[1] = '{8'h34, 2'b00, 8'h66, 16'h0000, 8'h10, 4'd7, 1'b1, 4'd6, 8'h3C, 16'h3C3C};
    vt[2] = '{8'h56, 2'b10, 8'h00, 16'hB100, 8'h21, 4'd9, 1'b1, 4'd0, 8'hE4, 16'hB1E4};
    vt[3] = '{8'h78, 2'b01, 8'h20, 16'h00C3, 8'h44, 4'd15, 1'b1, 4'd2, 8'h9D, 16'h9DC3};

    do_reset();
    #1;
    chk("reset_outputs", dut_out(), {15'd0, 1'b1, 1'b0, 44'd0, 3'd0});

    // Table: dispatch into an empty RS (with optional same-cycle bypass), issue next cycle.
    foreach (vt[k]) begin
      do_reset();
      disp(vt[k].op, vt[k].rdy, vt[k].tags, vt[k].vals, vt[k].wbs, vt[k].rob);
      bus.cdb_valid = vt[k].cdb_v;
      bus.cdb_id    = vt[k].cdb_id;
      bus.cdb_val   = vt[k].cdb_val;
      #1;
      chk("tbl_no_issue_empty", {63'd0, bus.fu_issue}, 64'd0);
      tick();
      idle();
      #1;
      chk("tbl_issue", dut_out(), {15'd0, 1'b1, 1'b1, vt[k].op, vt[k].exp_dep, vt[k].wbs,
                                   vt[k].op ^ 8'h5A, vt[k].rob, 3'd1});
      tick();
      #1;
      chk("tbl_drained", {62'd0, bus.fu_issue, bus.occupancy == 3'd0}, 64'd1);
    end

    // CDB wakeup of source 1: issue exactly one cycle after the broadcast.
    do_reset();
    disp(8'h21, 2'b01, 8'h50, 16'h0011, 8'h01, 4'd3);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wake_wait", {63'd0, bus.fu_issue}, 64'd0);
      tick();
    end
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = 4'd5;
    bus.cdb_val   = 8'hA9;
    #1;
    chk("wake_no_same_cycle", {63'd0, bus.fu_issue}, 64'd0);
    tick();
    idle();
    #1;
    chk("wake_issue", {47'd0, bus.fu_issue, bus.fu_depvals}, {47'd0, 1'b1, 16'hA911});

    // Fill, reject a fifth op, wake entry 2 out of order.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp(8'(i), 2'b00, {4'(i + 1), 4'(i + 1)}, 16'h0, 8'h0, 4'(i));
      tick();
    end
    idle();
    #1;
    chk("full_ready_low", {60'd0, bus.disp_ready, bus.occupancy}, {60'd0, 1'b0, 3'd4});
    disp(8'hFF, 2'b11, 8'h00, 16'hFFFF, 8'hFF, 4'd9);
    tick();
    idle();
    #1;
    chk("full_fifth_ignored", {60'd0, bus.fu_issue, bus.occupancy}, {60'd0, 1'b0, 3'd4});
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = 4'd3;
    bus.cdb_val   = 8'h77;
    tick();
    idle();
    #1;
    chk("ooo_issue_e2", {58'd0, bus.fu_issue, bus.disp_ready, bus.fu_robid},
        {58'd0, 1'b1, 1'b0, 4'd2});
    tick();
    #1;
    chk("ready_after_issue", {59'd0, bus.disp_ready, bus.fu_issue, bus.occupancy},
        {59'd0, 1'b1, 1'b0, 3'd3});

    // fu_hold blocks issue; nothing lost.
    do_reset();
    bus.fu_hold = 1'b1;
    disp(8'hA0, 2'b11, 8'h00, 16'h1111, 8'h0, 4'd0);
    tick();
    disp(8'hA1, 2'b11, 8'h00, 16'h2222, 8'h0, 4'd1);
    tick();
    idle();
    bus.fu_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_blocks", {60'd0, bus.fu_issue, bus.occupancy}, {60'd0, 1'b0, 3'd2});
      tick();
    end
    bus.fu_hold = 1'b0;
    #1;
    chk("hold_rel_e0", {59'd0, bus.fu_issue, bus.fu_robid}, {59'd0, 1'b1, 4'd0});
    tick();
    #1;
    chk("hold_rel_e1", {59'd0, bus.fu_issue, bus.fu_robid}, {59'd0, 1'b1, 4'd1});
    tick();
    #1;
    chk("hold_drained", {60'd0, bus.fu_issue, bus.occupancy}, 64'd0);

    // Flush beats same-cycle dispatch; rst during wakeup.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      disp(8'h0, 2'b00, 8'h77, 16'h0, 8'h0, 4'(i));
      tick();
    end
    disp(8'h0, 2'b11, 8'h00, 16'h0, 8'h0, 4'd4);
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    chk("flush_empty", {59'd0, bus.disp_ready, bus.fu_issue, bus.occupancy},
        {59'd0, 1'b1, 1'b0, 3'd0});
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = 4'd7;
    tick();
    idle();
    #1;
    chk("flush_no_issue", {63'd0, bus.fu_issue}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      disp(8'h0, 2'b00, 8'h88, 16'h0, 8'h0, 4'(i));
      tick();
    end
    idle();
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = 4'd8;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_mid_wake", {59'd0, bus.disp_ready, bus.fu_issue, bus.occupancy},
        {59'd0, 1'b1, 1'b0, 3'd0});
    tick();
    #1;
    chk("rst_mid_wake_quiet", {63'd0, bus.fu_issue}, 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.flush        = ($urandom_range(0, 99) < 2);
      bus.disp_valid   = $urandom_range(0, 1);
      bus.disp_operand = 8'($urandom);
      bus.disp_src_rdy = 2'($urandom);
      bus.disp_src_tag = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      bus.disp_src_val = 16'($urandom);
      bus.disp_wbs     = 8'($urandom);
      bus.disp_flags   = 8'($urandom);
      bus.disp_robid   = 4'($urandom);
      bus.cdb_valid    = ($urandom_range(0, 9) < 4);
      bus.cdb_id       = 4'($urandom_range(0, 3));
      bus.cdb_val      = 8'($urandom);
      bus.fu_hold      = ($urandom_range(0, 9) < 2);
      #1;
      model_cycle(e);
      chk("rand_cycle", dut_out(), e);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hash_rs.md
Name: hash_rs

Overview:
- Reservation station directly upstream of the hash functional unit.
- Buffers up to DEPTH dispatched hash micro-ops and snoops the CDB to capture missing source operands.
- Issues one ready op per cycle to the FU over the FU's input_transmit interface: operand, depvals, wbs, flags, robid.
- Back-pressures dispatch when full; throttles issue on the FU's registered hold indication.

Parameters:
- DEPTH, 4, number of entries (power of two, 2..8).
- TAG_W, 4, CDB/writeback tag width (matches cdb_id).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry; dispatch accepted iff disp_valid & disp_ready
- disp_operand  in  8  opcode/immediate field
- disp_src_rdy  in  2  per-source value-present bit
- disp_src_tag  in  2x4  per-source producer tag
- disp_src_val  in  2x8  per-source value (valid when rdy)
- disp_wbs  in  8  writeback selector
- disp_flags  in  8  flags
- disp_robid  in  4  ROB index
- cdb_valid  in  1  broadcast valid (end of the CDB transmit chain)
- cdb_id  in  4  broadcast tag
- cdb_val  in  8  broadcast value
- fu_hold  in  1  FU holds an undelivered result; registered in the FU, no combinational path from fu_issue
- fu_issue  out  1  to FU input_transmit
- fu_operand  out  8
- fu_depvals  out  2x8
- fu_wbs  out  8
- fu_flags  out  8
- fu_robid  out  4
- occupancy  out  $clog2(DEPTH)+1  valid-entry count

Behaviour:
- Reset clock and reset are clk and rst: synchronous, active-high.
- State per entry: valid, operand, rdy[1:0], tag[1:0], val[1:0], wbs, flags, robid.
- Reset, or flush, clears all valid bits the next edge; payload is don't-care. Flush wins over same-cycle dispatch and issue; the dispatched op is dropped.
- Reset output values: disp_ready=1, fu_issue=0, all fu_* data=0, occupancy=0.
- Allocation:
  - disp_ready = ~&valid, from registered state. A slot freed by issue in the same cycle is not reusable until the next cycle.
  - An accepted op is written into the lowest-index free entry at the edge.
- Dispatch-time CDB bypass: a source with disp_src_rdy=0, where cdb_valid and cdb_id==disp_src_tag in the same cycle, is written as rdy=1 with val=cdb_val.
- Wakeup: each cycle, for every valid entry and source with rdy=0 and tag==cdb_id while cdb_valid, set rdy=1 and val=cdb_val at the edge. Both sources may wake on one broadcast.
- Issue selection:
  - Combinational from registered state; an entry is eligible when valid & rdy[0] & rdy[1].
  - fu_issue = ~fu_hold & any eligible. The lowest-index eligible entry is chosen.
  - Its payload drives fu_*; the entry's valid clears at the edge.
  - When fu_issue=0, all fu_* data outputs are 0.
- Latency:
  - Dispatch with both sources ready → earliest issue the next cycle.
  - CDB wakeup at edge k → issuable in cycle k+1. There is no same-cycle CDB→issue path.
- fu_hold=1 blocks issue entirely. The FU stores at most one pending result, so issuing under hold would overwrite it.
- Simultaneous dispatch and issue: both take effect; occupancy is unchanged.
- occupancy is registered: +1 on accept, −1 on issue, 0 on flush or rst.
- Tag 0 is legal; matching is pure equality, qualified only by cdb_valid.

Decomposition:
- Shared package ooo_pkg: TAG_W, the rs_entry_t struct (valid, operand, rdy, tag, val, wbs, flags, robid), and the depvals_t = logic[1:0][7:0] typedef shared with the FU.
- One natural sub-module, rs_prio_enc: a lowest-index-first priority encoder, instantiated twice (free-slot select and ready select).

Test Plan:
- Dispatch operand=0x12, src_rdy=11, src_val={0x05,0x07}, wbs=0x03, robid=2 → next cycle fu_issue=1, fu_depvals={0x05,0x07}, fu_wbs=0x03, fu_robid=2; occupancy 1→0.
- Dispatch src_rdy=01, tag[1]=5; later cdb_valid, cdb_id=5, cdb_val=0xA9 → fu_issue asserts exactly one cycle after the broadcast, with fu_depvals[1]=0xA9.
- Dispatch src_rdy=00, tags 6/6, in the same cycle as cdb_valid, cdb_id=6, cdb_val=0x3C → bypass captured; issue next cycle with both depvals=0x3C.
- Fill 4 entries, none ready → disp_ready=0 and a fifth disp_valid is ignored. Wake entry 2 → it issues ahead of entries 0 and 1; disp_ready returns 1 the cycle after.
- Two ready entries with fu_hold held high for 3 cycles → fu_issue=0 throughout, with no entry lost. Drop fu_hold → entry 0 issues, then entry 1.
- Three valid entries; assert flush together with disp_valid → occupancy=0 and disp_ready=1 next cycle, no issue follows. Assert rst mid-wakeup → same empty state.
